i2c_fifo_sequencer: RTL
=======================

Name: i2c_fifo_sequencer

Overview:
Read-side controller for the I2C command FIFO. It pops one 15-bit addr+data entry at a time and hands it to the I2C master core with a start/done handshake. It retries NACKed transfers a bounded number of times, then drops the entry and reports an error. It sits between the FIFO's read port and the master core; it is the FIFO's only reader.

Parameters:
FIFO_WIDTH, 15, FIFO entry width; [14:8] = 7-bit slave addr, [7:0] = data byte
MAX_RETRY, 3, re-issues allowed after a NACK before the entry is dropped (0 = no retry)
RETRY_GAP, 16, idle cycles between a NACK and the re-issue (≥1)
TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (used only with SEQ_TIMEOUT_EN)

Ports:
i2c_clock_in  in  1  block clock
i2c_reset_n_in  in  1  reset: asynchronous, active-low
enable_in  in  1  1 = allow new FIFO pops
fifo_empty_in  in  1  FIFO empty flag
fifo_data_in  in  FIFO_WIDTH  FIFO registered read data
fifo_rd_en_out  out  1  FIFO read enable
master_busy_in  in  1  master core is mid-transfer
master_done_in  in  1  1-cycle pulse: transfer finished
master_nack_in  in  1  qualifies master_done_in: slave NACKed
master_start_out  out  1  1-cycle start pulse
master_addr_out  out  7  slave address, held stable from LOAD to IDLE
master_data_out  out  8  data byte, held stable from LOAD to IDLE
busy_out  out  1  state != IDLE
cmd_done_out  out  1  1-cycle pulse: entry transferred with ACK
cmd_err_out  out  1  1-cycle pulse: entry dropped after retries
timeout_out  out  1  1-cycle pulse: watchdog fired
err_count_out  out  8  dropped-entry count, saturates at 255

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0; retry and gap counters 0; err_count 0.
- All outputs are registered (Moore).
- States: IDLE, POP, LOAD, ISSUE, WAIT, GAP.
- IDLE:
  - enable_in && !fifo_empty_in -> POP.
- POP:
  - fifo_rd_en_out=1 for exactly this cycle.
  - FIFO updates fifo_data_in at this cycle's closing edge.
  - -> LOAD.
- LOAD:
  - capture fifo_data_in[14:8] into master_addr_out and [7:0] into master_data_out.
  - clear retry_cnt.
  - -> ISSUE.
- ISSUE:
  - if master_busy_in=1, hold with start=0.
  - else master_start_out=1 for one cycle and -> WAIT.
- Latency: condition sampled in IDLE at edge N gives start high in the cycle after edge N+3, when the master is not busy.
- WAIT:
  - done && !nack -> cmd_done_out pulse, -> IDLE.
  - done && nack && retry_cnt<MAX_RETRY -> retry_cnt++, -> GAP.
  - done && nack && retry_cnt==MAX_RETRY -> cmd_err_out pulse, err_count++ (saturating), -> IDLE. The entry is dropped.
- GAP:
  - count RETRY_GAP cycles, then -> ISSUE.
  - addr and data are unchanged for the re-issue.
- enable_in=0 mid-command: the current entry runs to completion or drop; no new pop after that.
- enable_in is ignored outside IDLE.
- master_done_in outside WAIT is ignored.
- master_nack_in is ignored unless master_done_in=1.
- Back-to-back: after the return to IDLE, the next pop needs at least one IDLE cycle.
- Single reader: fifo_rd_en_out is never asserted while fifo_empty_in was 1 when sampled in IDLE.
- Reset mid-operation aborts immediately: no pulses, and the popped entry is lost.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: a WAIT cycle counter is cleared on entry to WAIT. When it reaches TIMEOUT_CYCLES without master_done_in, the block pulses timeout_out and follows the NACK path (retry or drop).
- If master_done_in arrives in the same cycle the counter expires, done wins and there is no timeout.
- Undefined: WAIT has no limit; timeout_out is tied 0; no counter logic is present.

Test Plan:
- Single ACK: FIFO holds 0x52A5 (addr 0x52, data 0xA5), enable=1 -> one rd_en pulse, start 4 cycles after IDLE sample, addr=0x52, data=0xA5; done with nack=0 -> cmd_done pulse, busy=0.
- NACK retry: done with nack=1 twice, then ack -> exactly 3 starts, each separated by ≥16 GAP cycles; one cmd_done; err_count=0.
- Drop: MAX_RETRY=3, always NACK -> 4 starts, one cmd_err, err_count=1, next entry popped.
- Busy/enable: master_busy=1 for 10 cycles in ISSUE -> start held off until busy falls; enable dropped during WAIT -> entry completes, no further rd_en while 3 entries remain.
- Reset mid-WAIT: assert i2c_reset_n_in=0 asynchronously -> all outputs 0 before the next edge; after release, IDLE with err_count=0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> timeout pulse 8 cycles into WAIT, then GAP and a retry start; done on the expiry cycle -> cmd_done, no timeout.

Source files
------------

// File: rtl/i2c_fifo_sequencer.sv
// I2C command FIFO reader: pops addr+data entries, drives the master core.
// Optional WAIT watchdog enabled by defining SEQ_TIMEOUT_EN.
module i2c_fifo_sequencer #(
  parameter int FIFO_WIDTH     = 15,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i2c_clock_in,
  input  logic                  i2c_reset_n_in,
  input  logic                  enable_in,
  input  logic                  fifo_empty_in,
  input  logic [FIFO_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_rd_en_out,
  input  logic                  master_busy_in,
  input  logic                  master_done_in,
  input  logic                  master_nack_in,
  output logic                  master_start_out,
  output logic [6:0]            master_addr_out,
  output logic [7:0]            master_data_out,
  output logic                  busy_out,
  output logic                  cmd_done_out,
  output logic                  cmd_err_out,
  output logic                  timeout_out,
  output logic [7:0]            err_count_out
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GLAST = GW'(RETRY_GAP - 1);

  if (RETRY_GAP < 1 || TIMEOUT_CYCLES < 1 || FIFO_WIDTH < 15)
  begin : g_cfg_check
    $error("i2c_fifo_sequencer: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, ISSUE, WAIT, GAP
  } state_t;

  state_t        state;
  logic [RW-1:0] retry_cnt;
  logic [GW-1:0] gap_cnt;
  logic          wd_fire;
  logic          nack_fail;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_cnt;

  // Watchdog expires on the last allowed WAIT cycle; a done pulse wins.
  assign wd_fire = (state == WAIT) && !master_done_in &&
                   (wd_cnt == TLAST);
`else
  assign wd_fire     = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // A NACK and a watchdog expiry share the retry/drop path.
  assign nack_fail = (master_done_in && master_nack_in) || wd_fire;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
    if (!i2c_reset_n_in) begin
      state            <= IDLE;
      retry_cnt        <= '0;
      gap_cnt          <= '0;
      fifo_rd_en_out   <= 1'b0;
      master_start_out <= 1'b0;
      master_addr_out  <= '0;
      master_data_out  <= '0;
      busy_out         <= 1'b0;
      cmd_done_out     <= 1'b0;
      cmd_err_out      <= 1'b0;
      err_count_out    <= '0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt           <= '0;
      timeout_out      <= 1'b0;
`endif
    end else begin
      fifo_rd_en_out   <= 1'b0;
      master_start_out <= 1'b0;
      cmd_done_out     <= 1'b0;
      cmd_err_out      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout_out      <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (enable_in && !fifo_empty_in) begin
            fifo_rd_en_out <= 1'b1;
            busy_out       <= 1'b1;
            state          <= POP;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          master_addr_out <= fifo_data_in[14:8];
          master_data_out <= fifo_data_in[7:0];
          retry_cnt       <= '0;
          state           <= ISSUE;
        end
        ISSUE: begin
          if (!master_busy_in) begin
            master_start_out <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt           <= '0;
`endif
            state            <= WAIT;
          end
        end
        WAIT: begin
          if (master_done_in && !master_nack_in) begin
            cmd_done_out <= 1'b1;
            busy_out     <= 1'b0;
            state        <= IDLE;
          end else if (nack_fail) begin
`ifdef SEQ_TIMEOUT_EN
            timeout_out <= wd_fire;
`endif
            if (retry_cnt < RMAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= GAP;
            end else begin
              cmd_err_out <= 1'b1;
              if (err_count_out != 8'hFF)
                err_count_out <= err_count_out + 8'd1;
              busy_out    <= 1'b0;
              state       <= IDLE;
            end
          end else begin
`ifdef SEQ_TIMEOUT_EN
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        GAP: begin
          if (gap_cnt == GLAST)
            state <= ISSUE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
